// File: rtl/ds_scoreboard_pkg.sv
// ds_scoreboard shared definitions.
// Sizes and packed-bus field slicing for the decode scoreboard.

`ifndef DS_SCOREBOARD_PKG_SV
`define DS_SCOREBOARD_PKG_SV

// Field w bits wide at slot i of a packed bus.
`define SB_FIELD(bus, i, w) bus[(i)*(w) +: (w)]

package ds_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_AW    = 5;
    localparam int SB_NSRC  = 2;
    localparam int SB_NWB   = 1;
    localparam int SB_CNT_W = 2;
    localparam int SB_DEC_W = $clog2(SB_NWB + 1);

endpackage

`endif

// File: rtl/ds_scoreboard_if.sv
// ds_scoreboard decode/retire signal bundle.
// master drives the pipeline side, slave is the scoreboard.

interface ds_scoreboard_if
    import ds_scoreboard_pkg::*;
#(
    parameter int AW   = SB_AW,
    parameter int NSRC = SB_NSRC,
    parameter int NWB  = SB_NWB
);

    logic                iss_valid;
    logic                iss_ready;
    logic                iss_we;
    logic [AW-1:0]       iss_dest;
    logic [NSRC*AW-1:0]  iss_src;
    logic [NSRC-1:0]     fwd_avail;
    logic [NSRC-1:0]     src_pending;
    logic [NWB-1:0]      wb_valid;
    logic [NWB*AW-1:0]   wb_dest;
    logic                flush;
    logic                sb_busy;
    logic                sb_err;

    modport master (
        output iss_valid, iss_we, iss_dest, iss_src, fwd_avail,
        output wb_valid, wb_dest, flush,
        input  iss_ready, src_pending, sb_busy, sb_err
    );

    modport slave (
        input  iss_valid, iss_we, iss_dest, iss_src, fwd_avail,
        input  wb_valid, wb_dest, flush,
        output iss_ready, src_pending, sb_busy, sb_err
    );

endinterface

// File: rtl/ds_scoreboard_sb_counter.sv
// ds_scoreboard per-register in-flight writer counter.
// Underflow clamps to zero and is reported, never wraps.

module sb_counter
    import ds_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int DEC_W = SB_DEC_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             full,
    output logic             uflow
);

    localparam int W = (CNT_W + 1 > DEC_W) ? CNT_W + 1 : DEC_W;

    logic [W-1:0]     sum;
    logic [W-1:0]     dec_w;
    logic [CNT_W-1:0] cnt_d;

    // Next count: flush wins, then clamp on underflow.
    always_comb begin
        sum   = W'(cnt) + W'(inc);
        dec_w = W'(dec);
        uflow = 1'b0;
        cnt_d = CNT_W'(sum - dec_w);
        if (flush) begin
            cnt_d = '0;
        end else if (sum < dec_w) begin
            cnt_d = '0;
            uflow = 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    assign nz   = |cnt;
    assign full = &cnt;

endmodule

// File: rtl/ds_scoreboard.sv
// ds_scoreboard decode-stage register scoreboard.
// Counts in-flight writers per register; stalls issue on hazards.

module ds_scoreboard
    import ds_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int AW    = SB_AW,
    parameter int NSRC  = SB_NSRC,
    parameter int NWB   = SB_NWB,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic           clk,
    input  logic           resetn,
    ds_scoreboard_if.slave sb
);

    localparam int DEC_W = $clog2(NWB + 1);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  nz;
    logic [NREG-1:0]  full;
    logic [NREG-1:0]  uflow;
    logic [NSRC-1:0]  src_pend;
    logic [AW-1:0]    s;
    logic             src_stall;
    logic             dest_full;
    logic             ready;
    logic             fire;
    logic             err;

    // Register 0 is hardwired and never tracked.
    assign cnt[0]   = '0;
    assign nz[0]    = 1'b0;
    assign full[0]  = 1'b0;
    assign uflow[0] = 1'b0;

    // Source hazard lookup against registered counts.
    always_comb begin
        src_pend = '0;
        s        = '0;
        for (int i = 0; i < NSRC; i++) begin
            s           = `SB_FIELD(sb.iss_src, i, AW);
            src_pend[i] = (s != '0) && (cnt[s] != '0);
        end
    end

    assign src_stall = |(src_pend & ~sb.fwd_avail);
    assign dest_full = sb.iss_we && (sb.iss_dest != '0)
                       && full[sb.iss_dest];
    assign ready     = !sb.flush && !src_stall && !dest_full;
    assign fire      = sb.iss_valid && ready && sb.iss_we
                       && (sb.iss_dest != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [DEC_W-1:0] dec;
        logic             inc;

        assign inc = fire && (sb.iss_dest == AW'(r));

        // Count retire ports writing this register.
        always_comb begin
            dec = '0;
            for (int k = 0; k < NWB; k++) begin
                if (sb.wb_valid[k] &&
                    `SB_FIELD(sb.wb_dest, k, AW) == AW'(r)) begin
                    dec = dec + DEC_W'(1);
                end
            end
        end

        sb_counter #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk    (clk),
            .resetn (resetn),
            .inc    (inc),
            .dec    (dec),
            .flush  (sb.flush),
            .cnt    (cnt[r]),
            .nz     (nz[r]),
            .full   (full[r]),
            .uflow  (uflow[r])
        );
    end

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (|uflow) begin
            err <= 1'b1;
        end
    end

    assign sb.iss_ready   = ready;
    assign sb.src_pending = src_pend;
    assign sb.sb_busy     = |nz;
    assign sb.sb_err      = err;

endmodule

// File: tb/tb_ds_scoreboard.sv
// ds_scoreboard bench: directed scenarios plus random traffic.
// Expected outputs come from an integer count model in a queue.

module tb_ds_scoreboard;
    import ds_scoreboard_pkg::*;

    typedef struct {
        logic       ready;
        logic [1:0] pend;
        logic       busy;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    exp_t q[$];
    int   m_cnt[32];
    bit   m_err;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ds_scoreboard_if sb ();

    ds_scoreboard dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb)
    );

    task automatic check(string n, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err = 1'b0;
    endtask

    // One cycle of stimulus; the expected response is queued.
    task automatic cycle(bit v, bit we, int d, int s0, int s1,
                         bit [1:0] fwd, bit wbv, int wbd, bit fl);
        exp_t e;
        bit   stall;
        bit   dfull;
        bit   fire;
        @(posedge clk);
        #1;
        sb.iss_valid = v;
        sb.iss_we    = we;
        sb.iss_dest  = 5'(d);
        sb.iss_src   = {5'(s1), 5'(s0)};
        sb.fwd_avail = fwd;
        sb.wb_valid  = wbv;
        sb.wb_dest   = 5'(wbd);
        sb.flush     = fl;
        e.pend[0] = (s0 != 0) && (m_cnt[s0] > 0);
        e.pend[1] = (s1 != 0) && (m_cnt[s1] > 0);
        stall = (e.pend[0] && !fwd[0]) || (e.pend[1] && !fwd[1]);
        dfull = we && (d != 0) && (m_cnt[d] == 3);
        e.ready = !fl && !stall && !dfull;
        e.busy = 1'b0;
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) e.busy = 1'b1;
        e.err = m_err;
        q.push_back(e);
        fire = v && e.ready && we && (d != 0);
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            if (fire) m_cnt[d]++;
            if (wbv && wbd != 0) begin
                m_cnt[wbd]--;
                if (m_cnt[wbd] < 0) begin
                    m_cnt[wbd] = 0;
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs to the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("iss_ready", 8'(sb.iss_ready), 8'(e.ready));
                check("src_pending", 8'(sb.src_pending), 8'(e.pend));
                check("sb_busy", 8'(sb.sb_busy), 8'(e.busy));
                check("sb_err", 8'(sb.sb_err), 8'(e.err));
            end
        end
    end

    initial begin
        int d, s0, s1, wbd;
        sb.iss_valid = 0;
        sb.iss_we    = 0;
        sb.iss_dest  = '0;
        sb.iss_src   = '0;
        sb.fwd_avail = '0;
        sb.wb_valid  = '0;
        sb.wb_dest   = '0;
        sb.flush     = 0;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        idle();
        // Issue then dependent read, with and without bypass.
        cycle(1, 1, 5, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 5, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 5, 0, 2'b01, 0, 0, 0);
        // Saturate register 7, stall, retire, proceed.
        repeat (3) cycle(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 2'b00, 1, 7, 0);
        cycle(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 7, 0, 7, 2'b00, 0, 0, 0);
        // Simultaneous issue and retire on register 9.
        cycle(1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 9, 0, 0, 2'b00, 1, 9, 0);
        cycle(1, 0, 0, 9, 0, 2'b00, 0, 0, 0);
        // Underflow on 12 is sticky across flush; r0 retire ignored.
        cycle(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 2'b00, 1, 12, 0);
        cycle(1, 0, 0, 12, 0, 2'b00, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        idle();
        // Flush beats a concurrent issue and clears all counts.
        cycle(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 4, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 3, 3, 4, 2'b11, 0, 0, 1);
        cycle(1, 0, 0, 3, 4, 2'b00, 0, 0, 0);
        // Asynchronous reset mid-cycle with register 6 at 2.
        cycle(1, 1, 6, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 6, 0, 0, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        sb.iss_valid = 1;
        sb.iss_we    = 0;
        sb.iss_dest  = '0;
        sb.iss_src   = {5'd0, 5'd6};
        sb.fwd_avail = '0;
        sb.wb_valid  = '0;
        sb.flush     = 0;
        #1;
        check("pre_rst_pending", 8'(sb.src_pending), 8'h01);
        check("pre_rst_err", 8'(sb.sb_err), 8'h01);
        resetn = 1'b0;
        #1;
        check("rst_pending", 8'(sb.src_pending), 8'h00);
        check("rst_busy", 8'(sb.sb_busy), 8'h00);
        check("rst_ready", 8'(sb.iss_ready), 8'h01);
        check("rst_err", 8'(sb.sb_err), 8'h00);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        cycle(1, 1, 2, 6, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 2, 6, 2'b00, 0, 0, 0);

        // Random traffic over a small register window.
        for (int n = 0; n < 3000; n++) begin
            d   = $urandom_range(0, 7);
            s0  = $urandom_range(0, 7);
            s1  = $urandom_range(0, 7);
            wbd = $urandom_range(0, 7);
            for (int t = 0; t < 4 && m_cnt[wbd] == 0; t++)
                wbd = $urandom_range(1, 7);
            cycle(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0),
                  d, s0, s1, 2'($urandom),
                  1'($urandom_range(0, 2) == 0), wbd,
                  1'($urandom_range(0, 40) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 8'(q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
